// File: rtl/cpu_pkg.sv
// Shared types for the RV32I multi-cycle control path: ALU operations,
// sequencer states, halt reasons and the two supported opcodes.
package cpu_pkg;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      AND = 3'd2,
      OR  = 3'd3,
      XOR = 3'd4,
      SLL = 3'd5,
      SRL = 3'd6,
      SLT = 3'd7
   } alu_op_t;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      WRITEBACK,
      HALT
   } ctrl_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ZERO    = 2'b01,
      CAUSE_ILLEGAL = 2'b10,
      CAUSE_TIMEOUT = 2'b11
   } halt_cause_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of the R/I ALU subset: maps opcode/funct fields to an
// ALU operation, the immediate-operand select and a legality flag.
module alu_decoder
   import cpu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic [6:0] imm_hi,
   output alu_op_t    alu_op,
   output logic       use_imm,
   output logic       legal
);

   // SRA/SRAI and SLTU/SLTIU are deliberately left out of the legal set.
   always_comb begin
      alu_op  = ADD;
      use_imm = 1'b0;
      legal   = 1'b0;
      if (opcode == OP_RTYPE) begin
         if (funct7 == 7'b0000000) begin
            legal = 1'b1;
            case (funct3)
               3'b000:  alu_op = ADD;
               3'b001:  alu_op = SLL;
               3'b010:  alu_op = SLT;
               3'b100:  alu_op = XOR;
               3'b101:  alu_op = SRL;
               3'b110:  alu_op = OR;
               3'b111:  alu_op = AND;
               default: legal  = 1'b0;
            endcase
         end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            alu_op = SUB;
            legal  = 1'b1;
         end
      end else if (opcode == OP_ITYPE) begin
         use_imm = 1'b1;
         legal   = 1'b1;
         case (funct3)
            3'b000: alu_op = ADD;
            3'b010: alu_op = SLT;
            3'b100: alu_op = XOR;
            3'b110: alu_op = OR;
            3'b111: alu_op = AND;
            3'b001: begin
               alu_op = SLL;
               legal  = (imm_hi == 7'b0000000);
            end
            3'b101: begin
               alu_op = SRL;
               legal  = (imm_hi == 7'b0000000);
            end
            default: legal = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: fetches over a valid/req handshake, holds the IR,
// and steps FETCH->DECODE->EXECUTE->WRITEBACK, halting on zero/illegal/timeout.
module multicycle_control
   import cpu_pkg::*;
#(
   parameter int FETCH_TIMEOUT = 16,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_valid,
   input  logic [31:0]      instruction,
   output logic             ir_write,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [11:0]      imm12,
   output alu_op_t          alu_op,
   output logic             use_imm,
   output logic             reg_write,
   output logic             pc_write,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] retired
);

   localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(FETCH_TIMEOUT - 1);

   ctrl_state_t state;
   halt_cause_t cause_q;
   logic [31:0] ir;
   logic [TW-1:0] ctr;

   alu_op_t dec_op;
   logic    dec_use_imm;
   logic    dec_legal;

   assign rs1        = ir[19:15];
   assign rs2        = ir[24:20];
   assign rd         = ir[11:7];
   assign imm12      = ir[31:20];
   assign halt_cause = cause_q;

   // The IR latches on the same edge that ends a valid FETCH cycle, so the
   // pulse has to be visible during that cycle rather than one cycle later.
   assign ir_write = (state == FETCH) && imem_valid;

   alu_decoder u_alu_decoder (
      .opcode  (ir[6:0]),
      .funct3  (ir[14:12]),
      .funct7  (ir[31:25]),
      .imm_hi  (ir[31:25]),
      .alu_op  (dec_op),
      .use_imm (dec_use_imm),
      .legal   (dec_legal)
   );

   // Outputs are registered alongside the state so they line up with it;
   // alu_op/use_imm are captured in DECODE and held through WRITEBACK.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ir        <= 32'd0;
         ctr       <= '0;
         retired   <= '0;
         imem_req  <= 1'b0;
         alu_op    <= ADD;
         use_imm   <= 1'b0;
         reg_write <= 1'b0;
         pc_write  <= 1'b0;
         halted    <= 1'b0;
         cause_q   <= CAUSE_NONE;
      end else begin
         imem_req  <= 1'b0;
         reg_write <= 1'b0;
         pc_write  <= 1'b0;
         case (state)
            IDLE: begin
               if (run) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
               end
            end
            FETCH: begin
               if (imem_valid) begin
                  ir    <= instruction;
                  ctr   <= '0;
                  state <= DECODE;
               end else if (ctr == TIMEOUT_LAST) begin
                  state   <= HALT;
                  halted  <= 1'b1;
                  cause_q <= CAUSE_TIMEOUT;
               end else begin
                  ctr      <= ctr + TW'(1);
                  imem_req <= 1'b1;
               end
            end
            DECODE: begin
               if (ir == 32'd0) begin
                  state   <= HALT;
                  halted  <= 1'b1;
                  cause_q <= CAUSE_ZERO;
               end else if (dec_legal) begin
                  state   <= EXECUTE;
                  alu_op  <= dec_op;
                  use_imm <= dec_use_imm;
               end else begin
                  state   <= HALT;
                  halted  <= 1'b1;
                  cause_q <= CAUSE_ILLEGAL;
               end
            end
            EXECUTE: begin
               state     <= WRITEBACK;
               pc_write  <= 1'b1;
               reg_write <= (rd != 5'd0);
            end
            WRITEBACK: begin
               retired <= retired + CNT_W'(1);
               if (run) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
